// File: rtl/riscv_branch_pkg.sv
// Shared branch-resolution constants and the 2-bit saturating counter step.
package riscv_branch_pkg;

  // funct3 encodings of the RV64I conditional branches
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // 2-bit predictor counter states; MSB is the taken prediction
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Saturating step towards the resolved outcome
  function automatic logic [1:0] next_ctr(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_control_bht.sv
// Direct-mapped table of 2-bit saturating counters: one async read, one update port.
module branch_history_table
  import riscv_branch_pkg::*;
#(
  parameter int unsigned BHT_DEPTH = 16,
  parameter logic [1:0]  CTR_INIT  = WNT,
  localparam int unsigned IDX_W    = $clog2(BHT_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] ctr_q [BHT_DEPTH];
  logic [1:0] ctr_d [BHT_DEPTH];

  // Read returns the stored value; an update in the same cycle is not bypassed
  assign rd_ctr = ctr_q[rd_idx];

  // Next-state: step only the addressed counter on a resolved legal branch
  always_comb begin
    ctr_d = ctr_q;
    if (upd_en) begin
      ctr_d[upd_idx] = next_ctr(ctr_q[upd_idx], upd_taken);
    end
  end

  // Counter array with asynchronous reset to the initial weak state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr_q <= '{default: CTR_INIT};
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predict_control.sv
// EX-stage branch resolution, mispredict detection, predictor table and statistics.
module branch_predict_control
  import riscv_branch_pkg::*;
#(
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned PC_WIDTH  = 64,
  parameter int unsigned CNT_WIDTH = 32,
  parameter logic [1:0]  CTR_INIT  = WNT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  if_pc,
  output logic                 predict_taken,
  input  logic                 ex_branch,
  input  logic [PC_WIDTH-1:0]  ex_pc,
  input  logic [2:0]           ex_funct3,
  input  logic                 ex_zero,
  input  logic                 ex_lt,
  input  logic                 ex_ltu,
  input  logic                 ex_pred_taken,
  output logic                 switch_branch,
  output logic                 mispredict,
  output logic                 illegal_branch,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic [IDX_W-1:0]     if_idx;
  logic [IDX_W-1:0]     ex_idx;
  logic [1:0]           rd_ctr;
  logic                 cond_met;
  logic                 legal;
  logic                 upd_en;
  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d;
  logic [CNT_WIDTH-1:0] mispredict_count_q, mispredict_count_d;
  logic                 unused_bits;

  // Word-aligned PCs: drop the byte offset and index with the next IDX_W bits
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];

  // Only the index bits and the counter MSB are consumed
  assign unused_bits = ^{if_pc, ex_pc, rd_ctr[0]};

  branch_history_table #(
    .BHT_DEPTH (BHT_DEPTH),
    .CTR_INIT  (CTR_INIT)
  ) u_bht (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (if_idx),
    .rd_ctr    (rd_ctr),
    .upd_en    (upd_en),
    .upd_idx   (ex_idx),
    .upd_taken (cond_met)
  );

  assign predict_taken = rd_ctr[1];

  // Decode the branch condition and derive all resolution outputs
  always_comb begin
    cond_met = 1'b0;
    legal    = 1'b1;
    case (ex_funct3)
      F3_BEQ:  cond_met = ex_zero;
      F3_BNE:  cond_met = !ex_zero;
      F3_BLT:  cond_met = ex_lt;
      F3_BGE:  cond_met = !ex_lt;
      F3_BLTU: cond_met = ex_ltu;
      F3_BGEU: cond_met = !ex_ltu;
      default: legal    = 1'b0;
    endcase
    upd_en         = ex_branch && legal;
    switch_branch  = upd_en && cond_met;
    illegal_branch = ex_branch && !legal;
    mispredict     = upd_en && (cond_met != ex_pred_taken);
  end

  // Statistics next-state: saturate at all-ones instead of wrapping
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (upd_en && (branch_count_q != '1)) begin
      branch_count_d = branch_count_q + 1'b1;
    end
    if (mispredict && (mispredict_count_q != '1)) begin
      mispredict_count_d = mispredict_count_q + 1'b1;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predict_control.sv
// Randomized bench for branch_predict_control against a behavioural model.
module tb_branch_predict_control;

  localparam int unsigned BhtDepth = 16;
  localparam int unsigned PcWidth  = 64;
  localparam int unsigned CntWidth = 4;
  localparam int          CntMax   = (1 << CntWidth) - 1;
  localparam int          CtrInit  = 1;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [PcWidth-1:0]  if_pc = '0;
  logic                predict_taken;
  logic                ex_branch = 1'b0;
  logic [PcWidth-1:0]  ex_pc = '0;
  logic [2:0]          ex_funct3 = '0;
  logic                ex_zero = 1'b0;
  logic                ex_lt = 1'b0;
  logic                ex_ltu = 1'b0;
  logic                ex_pred_taken = 1'b0;
  logic                switch_branch;
  logic                mispredict;
  logic                illegal_branch;
  logic [CntWidth-1:0] branch_count;
  logic [CntWidth-1:0] mispredict_count;

  branch_predict_control #(
    .BHT_DEPTH (BhtDepth),
    .PC_WIDTH  (PcWidth),
    .CNT_WIDTH (CntWidth),
    .CTR_INIT  (2'b01)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .if_pc            (if_pc),
    .predict_taken    (predict_taken),
    .ex_branch        (ex_branch),
    .ex_pc            (ex_pc),
    .ex_funct3        (ex_funct3),
    .ex_zero          (ex_zero),
    .ex_lt            (ex_lt),
    .ex_ltu           (ex_ltu),
    .ex_pred_taken    (ex_pred_taken),
    .switch_branch    (switch_branch),
    .mispredict       (mispredict),
    .illegal_branch   (illegal_branch),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: counter strength per table slot as a plain integer 0..3, stats as ints
  int m_ctr [BhtDepth];
  int m_branches;
  int m_mispred;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int slot(input logic [63:0] pc);
    return int'((pc / 4) % BhtDepth);
  endfunction

  function automatic bit model_taken(input logic [2:0] f3, input logic [63:0] a,
                                     input logic [63:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < BhtDepth; i++) m_ctr[i] = CtrInit;
    m_branches = 0;
    m_mispred  = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 of the following cycle
  task automatic step(input logic br, input logic [63:0] pc, input logic [63:0] ipc,
                      input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                      input logic pred);
    bit legal, taken;
    int ei;
    ex_branch     = br;
    ex_pc         = pc;
    if_pc         = ipc;
    ex_funct3     = f3;
    ex_zero       = (a == b);
    ex_lt         = ($signed(a) < $signed(b));
    ex_ltu        = (a < b);
    ex_pred_taken = pred;
    legal = (f3 != 3'd2) && (f3 != 3'd3);
    taken = model_taken(f3, a, b);
    ei    = slot(pc);
    #1;
    check_eq("switch_branch", switch_branch, br && legal && taken);
    check_eq("mispredict", mispredict, br && legal && (taken != pred));
    check_eq("illegal_branch", illegal_branch, br && !legal);
    check_eq("predict_taken", predict_taken, m_ctr[slot(ipc)] >= 2);
    check_eq("branch_count", branch_count, m_branches);
    check_eq("mispredict_count", mispredict_count, m_mispred);
    @(posedge clk);
    if (br && legal) begin
      if (taken && m_ctr[ei] < 3) m_ctr[ei]++;
      if (!taken && m_ctr[ei] > 0) m_ctr[ei]--;
      if (m_branches < CntMax) m_branches++;
      if (taken != pred && m_mispred < CntMax) m_mispred++;
    end
    #1;
  endtask

  // Asynchronous reset asserted between edges, held over one edge with a legal branch present
  task automatic apply_reset(input logic [63:0] ipc);
    reset         = 1'b1;
    ex_branch     = 1'b1;
    ex_funct3     = 3'd0;
    ex_zero       = 1'b1;
    ex_pred_taken = 1'b0;
    ex_pc         = ipc;
    if_pc         = ipc;
    #1;
    model_reset();
    check_eq("rst_predict_taken", predict_taken, 0);
    check_eq("rst_branch_count", branch_count, 0);
    check_eq("rst_mispredict_count", mispredict_count, 0);
    @(posedge clk);
    #1;
    check_eq("rst_hold_predict", predict_taken, 0);
    check_eq("rst_hold_branch_count", branch_count, 0);
    reset     = 1'b0;
    ex_branch = 1'b0;
  endtask

  initial begin
    logic [63:0] pc, ipc, a, b;
    logic [2:0]  f3;
    logic        br, pred;

    #1;
    apply_reset(64'h0);

    // After reset every slot predicts not-taken
    for (int i = 0; i < BhtDepth; i++) begin
      step(1'b0, 64'h0, 64'(i * 4), 3'd0, 64'd0, 64'd0, 1'b0);
    end

    // BEQ training: 01 -> 10 -> 11 -> 11, all mispredicted against not-taken
    for (int i = 0; i < 3; i++) step(1'b1, 64'h100, 64'h100, 3'd0, 64'd7, 64'd7, 1'b0);
    step(1'b0, 64'h100, 64'h100, 3'd0, 64'd0, 64'd0, 1'b0);
    check_eq("beq_train_mispred", mispredict_count, 3);
    check_eq("beq_train_predict", predict_taken, 1);

    // Mid-run reset with trained counters and nonzero stats
    apply_reset(64'h100);
    step(1'b0, 64'h100, 64'h100, 3'd0, 64'd0, 64'd0, 1'b0);

    // Signed vs unsigned: a = -1, b = 1 gives lt=1, ltu=0
    step(1'b1, 64'h20, 64'h20, 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    step(1'b1, 64'h20, 64'h20, 3'b110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    step(1'b1, 64'h20, 64'h20, 3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);

    // Illegal funct3 leaves table and stats alone
    step(1'b1, 64'h20, 64'h20, 3'b010, 64'd3, 64'd3, 1'b1);
    step(1'b1, 64'h20, 64'h20, 3'b011, 64'd3, 64'd4, 1'b0);
    step(1'b0, 64'h20, 64'h20, 3'd0, 64'd0, 64'd0, 1'b0);

    // Aliased same-cycle lookup: pre-update value now, updated value next cycle
    apply_reset(64'h0);
    step(1'b1, 64'h104, 64'h144, 3'd0, 64'd5, 64'd5, 1'b1);
    step(1'b0, 64'h104, 64'h144, 3'd0, 64'd0, 64'd0, 1'b0);
    check_eq("alias_predict_after", predict_taken, 1);

    // Statistics saturation with a 4-bit width
    apply_reset(64'h0);
    for (int i = 0; i < 17; i++) step(1'b1, 64'h40, 64'h40, 3'd0, 64'd1, 64'd1, 1'b0);
    step(1'b0, 64'h40, 64'h40, 3'd0, 64'd0, 64'd0, 1'b0);
    check_eq("sat_branch_count", branch_count, 4'hF);
    check_eq("sat_mispredict_count", mispredict_count, 4'hF);

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(39) == 0) begin
        apply_reset({$urandom(), $urandom()});
      end else begin
        pc = {$urandom(), $urandom()};
        if ($urandom_range(1) == 1) ipc = pc + 64'(BhtDepth * 4 * $urandom_range(3));
        else ipc = {$urandom(), $urandom()};
        a = {$urandom(), $urandom()};
        case ($urandom_range(3))
          0:       b = a;
          1:       b = -a;
          2:       b = a + 64'($urandom_range(2)) - 64'd1;
          default: b = {$urandom(), $urandom()};
        endcase
        f3   = 3'($urandom_range(7));
        br   = ($urandom_range(9) < 8);
        pred = 1'($urandom_range(1));
        step(br, pc, ipc, f3, a, b, pred);
      end
    end
    step(1'b0, 64'h0, 64'h0, 3'd0, 64'd0, 64'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
